adc_trig_capture: RTL

//   Parametrised successor to the AD9481 capture/data-processing path: arms on a start pulse, captures

---
 rtl/adc_cap_pkg.sv | 30 +++
 rtl/adc_cap_ram.sv | 37 +++
 rtl/adc_trig_capture.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_cap_pkg.sv
// rtl/adc_cap_pkg.sv - shared types, trigger-mode codes and threshold compare for the ADC capture block
package adc_cap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_READ      = 3'd4
    } cap_state_e;

    localparam logic [1:0] TRIG_FORCE   = 2'd0;
    localparam logic [1:0] TRIG_RISING  = 2'd1;
    localparam logic [1:0] TRIG_FALLING = 2'd2;
    localparam logic [1:0] TRIG_EXT     = 2'd3;

    // a < b on a w-bit lane value; signed compare is done by flipping the
    // sign bit so one unsigned comparator serves both modes
    function automatic logic lane_lt(input logic [31:0] a, input logic [31:0] b,
                                     input int w, input bit is_signed);
        logic [31:0] msb;
        logic [31:0] ax;
        logic [31:0] bx;
        msb = 32'd1 << (w - 1);
        ax  = is_signed ? (a ^ msb) : a;
        bx  = is_signed ? (b ^ msb) : b;
        return ax < bx;
    endfunction

endpackage

// File: rtl/adc_cap_ram.sv
// rtl/adc_cap_ram.sv - simple dual-port synchronous RAM for the capture buffer
module adc_cap_ram
    import adc_cap_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    // write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // registered read port; output holds while re_i is low
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_trig_capture.sv
// rtl/adc_trig_capture.sv - triggered ADC frame capture with pre-trigger history and stream readout
module adc_trig_capture
    import adc_cap_pkg::*;
#(
    parameter int LANE_W   = 8,
    parameter int NCH      = 2,
    parameter int DEPTH    = 4096,
    parameter int PRE_TRIG = 1024,
    parameter int DEC_W    = 8,
    parameter int SIGNED   = 0,
    localparam int SEL_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH*LANE_W-1:0] adc_in,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            trig_mode,
    input  logic [SEL_W-1:0]      trig_lane,
    input  logic [LANE_W-1:0]     trig_level,
    input  logic                  ext_trig,
    input  logic [DEC_W-1:0]      decim,
    output logic                  busy,
    output logic                  triggered,
    output logic [NCH*LANE_W-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam int AW     = $clog2(DEPTH);
    localparam int W      = NCH * LANE_W;
    localparam int POST_N = DEPTH - PRE_TRIG - 1;

    cap_state_e          state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]       trig_addr_q, trig_addr_d;
    logic [AW:0]         cnt_q, cnt_d;
    logic [AW:0]         rd_cnt_q, rd_cnt_d;
    logic [DEC_W-1:0]    dec_cnt_q, dec_cnt_d;
    logic [DEC_W-1:0]    decim_q, decim_d;
    logic [1:0]          mode_q, mode_d;
    logic [SEL_W-1:0]    lane_q, lane_d;
    logic [LANE_W-1:0]   level_q, level_d;
    logic [LANE_W-1:0]   prev_q, prev_d;
    logic                prev_valid_q, prev_valid_d;
    logic                triggered_q, triggered_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q, m_last_d;

    logic                ram_we;
    logic                ram_re;
    logic [W-1:0]        ram_rdata;
    logic [LANE_W-1:0]   cur_lane;
    logic                capturing;
    logic                strobe;
    logic                cur_lt;
    logic                prev_lt;
    logic                trig_hit;
    logic                enter_read;
    logic                can_issue;

    // lane selection, decimation strobe and trigger condition
    always_comb begin
        cur_lane = adc_in[LANE_W-1:0];
        for (int i = 0; i < NCH; i++) begin
            if (lane_q == SEL_W'(i)) begin
                cur_lane = adc_in[i*LANE_W +: LANE_W];
            end
        end
        capturing = (state_q == ST_PRE) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POST);
        strobe    = capturing && (dec_cnt_q == decim_q);
        cur_lt    = lane_lt(32'(cur_lane), 32'(level_q), LANE_W, SIGNED != 0);
        prev_lt   = lane_lt(32'(prev_q), 32'(level_q), LANE_W, SIGNED != 0);
        case (mode_q)
            TRIG_FORCE:   trig_hit = 1'b1;
            TRIG_RISING:  trig_hit = prev_valid_q && prev_lt && !cur_lt;
            TRIG_FALLING: trig_hit = prev_valid_q && !prev_lt && cur_lt;
            default:      trig_hit = ext_trig;
        endcase
    end

    // next-state logic for capture and readout; abort overrides everything
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        trig_addr_d  = trig_addr_q;
        cnt_d        = cnt_q;
        rd_cnt_d     = rd_cnt_q;
        dec_cnt_d    = dec_cnt_q;
        decim_d      = decim_q;
        mode_d       = mode_q;
        lane_d       = lane_q;
        level_d      = level_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        triggered_d  = triggered_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        enter_read   = 1'b0;
        can_issue    = 1'b0;

        if (capturing) begin
            dec_cnt_d = strobe ? '0 : dec_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d       = trig_mode;
                    lane_d       = trig_lane;
                    level_d      = trig_level;
                    decim_d      = decim;
                    wr_ptr_d     = '0;
                    cnt_d        = '0;
                    dec_cnt_d    = '0;
                    prev_valid_d = 1'b0;
                    triggered_d  = 1'b0;
                    state_d      = (PRE_TRIG == 0) ? ST_WAIT_TRIG : ST_PRE;
                end
            end
            ST_PRE: begin
                if (strobe) begin
                    ram_we       = 1'b1;
                    wr_ptr_d     = wr_ptr_q + 1'b1;
                    cnt_d        = cnt_q + 1'b1;
                    prev_d       = cur_lane;
                    prev_valid_d = 1'b1;
                    if (int'(cnt_q) == PRE_TRIG - 1) begin
                        state_d = ST_WAIT_TRIG;
                    end
                end
            end
            ST_WAIT_TRIG: begin
                if (strobe) begin
                    ram_we       = 1'b1;
                    wr_ptr_d     = wr_ptr_q + 1'b1;
                    prev_d       = cur_lane;
                    prev_valid_d = 1'b1;
                    if (trig_hit) begin
                        trig_addr_d = wr_ptr_q;
                        triggered_d = 1'b1;
                        cnt_d       = '0;
                        if (POST_N == 0) begin
                            enter_read = 1'b1;
                        end else begin
                            state_d = ST_POST;
                        end
                    end
                end
            end
            ST_POST: begin
                if (strobe) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (int'(cnt_q) == POST_N - 1) begin
                        enter_read = 1'b1;
                    end
                end
            end
            ST_READ: begin
                // the RAM output register is the single prefetch stage: a new
                // read is issued whenever that stage is empty or being drained
                can_issue = (!m_valid_q || m_ready) && (int'(rd_cnt_q) != DEPTH);
                if (can_issue) begin
                    ram_re    = 1'b1;
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    rd_cnt_d  = rd_cnt_q + 1'b1;
                    m_valid_d = 1'b1;
                    m_last_d  = (int'(rd_cnt_q) == DEPTH - 1);
                end else if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                end
                if (m_valid_q && m_ready && m_last_q) begin
                    state_d   = ST_IDLE;
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_read) begin
            state_d  = ST_READ;
            rd_ptr_d = trig_addr_d - AW'(PRE_TRIG);
            rd_cnt_d = '0;
        end

        if (abort) begin
            state_d     = ST_IDLE;
            m_valid_d   = 1'b0;
            m_last_d    = 1'b0;
            triggered_d = 1'b0;
            ram_we      = 1'b0;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            trig_addr_q  <= '0;
            cnt_q        <= '0;
            rd_cnt_q     <= '0;
            dec_cnt_q    <= '0;
            decim_q      <= '0;
            mode_q       <= '0;
            lane_q       <= '0;
            level_q      <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            triggered_q  <= 1'b0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            trig_addr_q  <= trig_addr_d;
            cnt_q        <= cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            dec_cnt_q    <= dec_cnt_d;
            decim_q      <= decim_d;
            mode_q       <= mode_d;
            lane_q       <= lane_d;
            level_q      <= level_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            triggered_q  <= triggered_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
        end
    end

    adc_cap_ram #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (adc_in),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign busy      = (state_q != ST_IDLE);
    assign triggered = triggered_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    // RAM output is not reset, so gate it to keep m_data at zero when idle
    assign m_data    = m_valid_q ? ram_rdata : '0;

endmodule
